// File: rtl/tpu_pkg.sv
// Shared types and constants for the uTPU command sequencer.
//   opcode_e    : instruction opcodes (6 and 7 are illegal)
//   seq_state_e : sequencer FSM states, also exported on the debug port
//   FLAG_*      : bit positions inside the 3-bit flag field
//   ERR_*       : err_code encodings
package tpu_pkg;

  typedef enum logic [2:0] {
    OP_NOP   = 3'd0,
    OP_STORE = 3'd1,
    OP_FETCH = 3'd2,
    OP_RUN   = 3'd3,
    OP_LOAD  = 3'd4,
    OP_HALT  = 3'd5
  } opcode_e;

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_FETCH_BYTE = 3'd1,
    ST_DECODE     = 3'd2,
    ST_OPERAND    = 3'd3,
    ST_ISSUE      = 3'd4,
    ST_WAIT_DONE  = 3'd5,
    ST_HALT       = 3'd6,
    ST_ERROR      = 3'd7
  } seq_state_e;

  // Flag field bit indices
  localparam int FLAG_EXT = 0;
  localparam int FLAG_LEN = 1;

  // Field positions inside an instruction word
  localparam int FLAGS_LSB       = 3;
  localparam int INLINE_ADDR_LSB = 6;

  localparam logic [1:0] ERR_NONE    = 2'b00;
  localparam logic [1:0] ERR_ILLEGAL = 2'b01;
  localparam logic [1:0] ERR_TIMEOUT = 2'b10;

endpackage

// File: rtl/word_assembler.sv
// Little-endian byte-to-word assembler.
// The first byte accepted lands in the least significant byte of the word.
// Ports:
//   clk, rst_n  : clock, asynchronous active-low reset
//   clr         : synchronous clear of the byte count (drops a partial word)
//   byte_en     : a byte is accepted at this edge
//   byte_in     : the byte being accepted
//   word        : assembled word including the byte currently presented;
//                 complete whenever word_done is high
//   word_done   : byte_en on the final byte of a word (combinational)
module word_assembler #(
  parameter int BYTE_W = 8,
  parameter int WORD_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              byte_en,
  input  logic [BYTE_W-1:0] byte_in,
  output logic [WORD_W-1:0] word,
  output logic              word_done
);

  localparam int N_BYTES = WORD_W / BYTE_W;

  generate
    if (N_BYTES == 1) begin : g_single
      assign word      = byte_in;
      assign word_done = byte_en;
    end else begin : g_multi
      localparam int CNT_W = $clog2(N_BYTES);
      localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N_BYTES - 1);

      logic [CNT_W-1:0]  cnt_q;
      logic [WORD_W-1:0] shift_q;

      // The new byte enters at the top and earlier bytes move down, so after
      // N_BYTES bytes the first byte sits in the low byte lane.
      assign word      = {byte_in, shift_q[WORD_W-1:BYTE_W]};
      assign word_done = byte_en && (cnt_q == CNT_LAST);

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          cnt_q   <= '0;
          shift_q <= '0;
        end else if (clr) begin
          cnt_q   <= '0;
        end else if (byte_en) begin
          shift_q <= word;
          cnt_q   <= word_done ? '0 : cnt_q + 1'b1;
        end
      end
    end
  endgenerate

endmodule

// File: rtl/tpu_cmd_sequencer.sv
// uTPU instruction sequencer.
// Pulls instruction bytes from the RX FIFO, assembles little-endian words,
// decodes them, fetches optional address/length operand words and issues one
// command per instruction to the datapath, then waits for cmd_done.
// Optional build macro: TPU_SEQ_PERF_CNT_EN adds perf_instr_cnt/perf_stall_cnt.
// Ports:
//   clk, rst_n           : clock, asynchronous active-low reset
//   start                : leaves IDLE, HALT or ERROR (ignored elsewhere)
//   rx_data/rx_valid     : RX FIFO head byte (fall-through) / not empty
//   rx_re                : pop RX FIFO, byte consumed at this edge
//   cmd_valid/cmd_ready  : command handshake to the datapath
//   cmd_op/flags/addr/len: command payload
//   cmd_done             : datapath finished the command
//   busy/halted/err      : status; err_code 01 illegal opcode, 10 timeout
//   state_dbg            : current FSM state
module tpu_cmd_sequencer
  import tpu_pkg::*;
#(
  parameter int FIFO_DATA_WIDTH = 8,
  parameter int INSTR_W         = 16,
  parameter int OPCODE_WIDTH    = 3,
  parameter int ADDR_W          = 9,
  parameter int LEN_W           = 8,
  parameter int TIMEOUT_CYCLES  = 1024
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       start,
  input  logic [FIFO_DATA_WIDTH-1:0] rx_data,
  input  logic                       rx_valid,
  output logic                       rx_re,
  output logic                       cmd_valid,
  input  logic                       cmd_ready,
  output logic [OPCODE_WIDTH-1:0]    cmd_op,
  output logic [2:0]                 cmd_flags,
  output logic [ADDR_W-1:0]          cmd_addr,
  output logic [LEN_W-1:0]           cmd_len,
  input  logic                       cmd_done,
  output logic                       busy,
  output logic                       halted,
  output logic                       err,
  output logic [1:0]                 err_code,
`ifdef TPU_SEQ_PERF_CNT_EN
  output logic [31:0]                perf_instr_cnt,
  output logic [31:0]                perf_stall_cnt,
`endif
  output seq_state_e                 state_dbg
);

  localparam int WD_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [WD_W-1:0] WD_LAST =
    WD_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

  seq_state_e state_q, state_d;

  logic [INSTR_W-1:0]      instr_q;
  logic [INSTR_W-1:0]      instr_sh;
  logic [INSTR_W-1:0]      wa_word;
  logic                    wa_done;
  logic                    wa_clr;
  logic [OPCODE_WIDTH-1:0] dec_op;
  logic [2:0]              dec_flags;
  logic [ADDR_W-1:0]       dec_addr;
  logic                    dec_nop, dec_halt, dec_illegal, need_operand;
  logic                    op_ptr_q;   // 0: address operand pending, 1: length pending
  logic [WD_W-1:0]         wd_cnt_q;
  logic                    wd_expired;
  logic [1:0]              err_code_q;
  logic                    unused_bits;

  // Bytes are accepted in FETCH_BYTE and OPERAND whenever the FIFO has data;
  // an empty FIFO simply holds the partial word in the assembler.
  word_assembler #(
    .BYTE_W (FIFO_DATA_WIDTH),
    .WORD_W (INSTR_W)
  ) u_word_asm (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr       (wa_clr),
    .byte_en   (rx_re),
    .byte_in   (rx_data),
    .word      (wa_word),
    .word_done (wa_done)
  );

  assign wa_clr = start && (state_q == ST_IDLE || state_q == ST_HALT || state_q == ST_ERROR);

  // Inline address is everything above the flags, truncated/zero-extended to ADDR_W.
  assign instr_sh     = instr_q >> INLINE_ADDR_LSB;
  assign dec_op       = instr_q[OPCODE_WIDTH-1:0];
  assign dec_flags    = instr_q[FLAGS_LSB +: 3];
  assign dec_addr     = instr_sh[ADDR_W-1:0];
  assign dec_nop      = (dec_op == OPCODE_WIDTH'(OP_NOP));
  assign dec_halt     = (dec_op == OPCODE_WIDTH'(OP_HALT));
  assign dec_illegal  = (dec_op >  OPCODE_WIDTH'(OP_HALT));
  assign need_operand = dec_flags[FLAG_EXT] | dec_flags[FLAG_LEN];
  assign wd_expired   = (TIMEOUT_CYCLES != 0) && (wd_cnt_q == WD_LAST);
  assign unused_bits  = ^{instr_sh, wa_word};

  // Command handshake: cmd_valid is high for the whole ISSUE state and the
  // payload registers are frozen there; the command transfers on the first
  // edge where cmd_valid && cmd_ready, and cmd_valid is low from the next cycle.
  always_comb begin
    state_d = state_q;
    rx_re   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) state_d = ST_FETCH_BYTE;
      end
      ST_FETCH_BYTE: begin
        rx_re = rx_valid;
        if (wa_done) state_d = ST_DECODE;
      end
      ST_DECODE: begin
        if (dec_nop)           state_d = ST_FETCH_BYTE;
        else if (dec_halt)     state_d = ST_HALT;
        else if (dec_illegal)  state_d = ST_ERROR;
        else if (need_operand) state_d = ST_OPERAND;
        else                   state_d = ST_ISSUE;
      end
      ST_OPERAND: begin
        rx_re = rx_valid;
        if (wa_done && (op_ptr_q || !dec_flags[FLAG_LEN])) state_d = ST_ISSUE;
      end
      ST_ISSUE: begin
        if (cmd_ready) state_d = ST_WAIT_DONE;
      end
      ST_WAIT_DONE: begin
        if (cmd_done)        state_d = ST_FETCH_BYTE;
        else if (wd_expired) state_d = ST_ERROR;
      end
      ST_HALT, ST_ERROR: begin
        if (start) state_d = ST_FETCH_BYTE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      instr_q    <= '0;
      op_ptr_q   <= 1'b0;
      wd_cnt_q   <= '0;
      err_code_q <= ERR_NONE;
      cmd_op     <= '0;
      cmd_flags  <= '0;
      cmd_addr   <= '0;
      cmd_len    <= '0;
    end else begin
      state_q <= state_d;

      if (state_q == ST_FETCH_BYTE && wa_done) instr_q <= wa_word;

      if (state_q == ST_DECODE) begin
        cmd_op    <= dec_op;
        cmd_flags <= dec_flags;
        cmd_addr  <= dec_addr;
        cmd_len   <= '0;
        op_ptr_q  <= ~dec_flags[FLAG_EXT];   // skip straight to length if no EXT
      end

      if (state_q == ST_OPERAND && wa_done) begin
        if (!op_ptr_q) begin
          cmd_addr <= wa_word[ADDR_W-1:0];
          op_ptr_q <= 1'b1;
        end else begin
          cmd_len  <= wa_word[LEN_W-1:0];
        end
      end

      // Counts cycles spent in WAIT_DONE; zero on the first one.
      if (state_q == ST_WAIT_DONE) wd_cnt_q <= wd_cnt_q + 1'b1;
      else                         wd_cnt_q <= '0;

      if (state_d == ST_ERROR && state_q == ST_DECODE)         err_code_q <= ERR_ILLEGAL;
      else if (state_d == ST_ERROR && state_q == ST_WAIT_DONE) err_code_q <= ERR_TIMEOUT;
      else if (state_q == ST_ERROR && start)                   err_code_q <= ERR_NONE;
    end
  end

  assign cmd_valid = (state_q == ST_ISSUE);
  assign busy      = !(state_q == ST_IDLE || state_q == ST_HALT || state_q == ST_ERROR);
  assign halted    = (state_q == ST_HALT);
  assign err       = (state_q == ST_ERROR);
  assign err_code  = err_code_q;
  assign state_dbg = state_q;

`ifdef TPU_SEQ_PERF_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_instr_cnt <= '0;
      perf_stall_cnt <= '0;
    end else begin
      if (state_q == ST_DECODE) perf_instr_cnt <= perf_instr_cnt + 32'd1;
      if (((state_q == ST_FETCH_BYTE || state_q == ST_OPERAND) && !rx_valid) ||
          (state_q == ST_ISSUE && !cmd_ready))
        perf_stall_cnt <= perf_stall_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_tpu_cmd_sequencer.sv
// Bench for tpu_cmd_sequencer: an RX FIFO model feeds bytes, expected commands
// are queued as instructions are pushed and compared on every handshake.
module tb_tpu_cmd_sequencer;
  import tpu_pkg::*;

  localparam int W = 23;  // {op[2:0], flags[2:0], addr[8:0], len[7:0]}

  // ---------------- clock / reset ----------------
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic       rx_valid = 1'b0;
  logic       rx_re;
  logic       cmd_valid;
  logic       cmd_ready = 1'b0;
  logic [2:0] cmd_op, cmd_flags;
  logic [8:0] cmd_addr;
  logic [7:0] cmd_len;
  logic       cmd_done = 1'b0;
  logic       busy, halted, err;
  logic [1:0] err_code;
  seq_state_e state_dbg;
`ifdef TPU_SEQ_PERF_CNT_EN
  logic [31:0] perf_instr_cnt, perf_stall_cnt;
`endif

  always #5 clk = ~clk;

  tpu_cmd_sequencer #(
    .FIFO_DATA_WIDTH (8),
    .INSTR_W         (16),
    .OPCODE_WIDTH    (3),
    .ADDR_W          (9),
    .LEN_W           (8),
    .TIMEOUT_CYCLES  (16)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .rx_re     (rx_re),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_flags (cmd_flags),
    .cmd_addr  (cmd_addr),
    .cmd_len   (cmd_len),
    .cmd_done  (cmd_done),
    .busy      (busy),
    .halted    (halted),
    .err       (err),
    .err_code  (err_code),
`ifdef TPU_SEQ_PERF_CNT_EN
    .perf_instr_cnt (perf_instr_cnt),
    .perf_stall_cnt (perf_stall_cnt),
`endif
    .state_dbg (state_dbg)
  );

  // ---------------- checking ----------------
  int n_cmp = 0;
  int n_err = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // ---------------- RX FIFO model ----------------
  logic [7:0] rx_q[$];
  logic       pop_now;

  task automatic rx_refresh();
    rx_valid = (rx_q.size() != 0);
    rx_data  = rx_valid ? rx_q[0] : 8'h00;
  endtask

  always @(posedge clk) begin
    pop_now = rx_re;
    #1;
    if (pop_now && rx_q.size() != 0) void'(rx_q.pop_front());
    rx_refresh();
  end

  // ---------------- scoreboard / monitor ----------------
  logic [W-1:0] exp_q[$];
  logic [W-1:0] exp_word;
  int   cyc = 0, last_pop_cyc = 0, first_valid_cyc = 0, hs_cnt = 0;
  int   wd_run = 0, wd_last = 0;
  logic valid_prev = 1'b0;

  always @(negedge clk) begin
    cyc++;
    if (rx_re) last_pop_cyc = cyc;
    if (cmd_valid && !valid_prev) first_valid_cyc = cyc;
    valid_prev = cmd_valid;
    if (state_dbg == ST_WAIT_DONE) wd_run++;
    else if (wd_run != 0) begin
      wd_last = wd_run;
      wd_run  = 0;
    end
    if (rst_n && cmd_valid && cmd_ready) begin
      hs_cnt++;
      check_eq("sb_pending", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        exp_word = exp_q.pop_front();
        check_eq("cmd_payload", 32'({cmd_op, cmd_flags, cmd_addr, cmd_len}), 32'(exp_word));
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic push_word(input logic [15:0] w);
    rx_q.push_back(w[7:0]);
    rx_q.push_back(w[15:8]);
    rx_refresh();
  endtask

  // Builds the instruction word plus operands and queues the command it should produce.
  task automatic push_instr(input logic [2:0] op, input logic [2:0] flags, input logic [9:0] inl,
                            input logic [15:0] ext_w, input logic [15:0] len_w);
    logic [8:0] a;
    logic [7:0] l;
    push_word({inl, flags, op});
    if (flags[0]) push_word(ext_w);
    if (flags[1]) push_word(len_w);
    a = flags[0] ? ext_w[8:0] : inl[8:0];
    l = flags[1] ? len_w[7:0] : 8'h00;
    if (op >= 3'd1 && op <= 3'd4) exp_q.push_back({op, flags, a, l});
  endtask

  task automatic wait_valid(input int max);
    int n = 0;
    while (!cmd_valid && n < max) begin
      tick();
      n++;
    end
    check_eq("cmd_valid_seen", 32'(cmd_valid), 32'd1);
  endtask

  task automatic wait_state(input string tag, input seq_state_e s, input int max);
    int n = 0;
    while (state_dbg != s && n < max) begin
      tick();
      n++;
    end
    check_eq(tag, 32'(state_dbg), 32'(s));
  endtask

  // Waits for a command, optionally holds ready low, accepts it, then pulses done.
  task automatic serve_cmd(input int stall, input int done_delay, input bit done_at_hs);
    logic [W-1:0] p0;
    wait_valid(200);
    p0 = {cmd_op, cmd_flags, cmd_addr, cmd_len};
    for (int i = 0; i < stall; i++) begin
      cmd_ready = 1'b0;
      tick();
      check_eq("stall_valid", 32'(cmd_valid), 32'd1);
      check_eq("stall_payload", 32'({cmd_op, cmd_flags, cmd_addr, cmd_len}), 32'(p0));
      check_eq("stall_no_pop", 32'(rx_re), 32'd0);
    end
    cmd_ready = 1'b1;
    cmd_done  = done_at_hs;
    tick();
    cmd_ready = 1'b0;
    cmd_done  = 1'b0;
    check_eq("valid_drop", 32'(cmd_valid), 32'd0);
    if (done_at_hs) begin
      tick();
      check_eq("hs_done_ignored", 32'(state_dbg), 32'(ST_WAIT_DONE));
    end
    if (done_delay >= 0) begin
      repeat (done_delay) tick();
      cmd_done = 1'b1;
      tick();
      cmd_done = 1'b0;
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [2:0]  op, fl;
    logic [9:0]  inl;
    logic [15:0] ew, lw;
    int          hs0;

    rx_refresh();
    rst_n = 1'b0;
    repeat (3) tick();
    check_eq("rst_cmd_valid", 32'(cmd_valid), 32'd0);
    check_eq("rst_rx_re", 32'(rx_re), 32'd0);
    check_eq("rst_status", 32'({busy, halted, err, err_code}), 32'd0);
    check_eq("rst_payload", 32'({cmd_op, cmd_flags, cmd_addr, cmd_len}), 32'd0);
    check_eq("rst_state", 32'(state_dbg), 32'(ST_IDLE));
    rst_n = 1'b1;
    tick();
    check_eq("idle_hold", 32'(state_dbg), 32'(ST_IDLE));

    // RUN with inline address 5 (bytes 0x43, 0x01)
    pulse_start();
    check_eq("start_busy", 32'(busy), 32'd1);
    push_instr(OP_RUN, 3'b000, 10'd5, 16'h0, 16'h0);
    check_eq("run_word_bytes", 32'({rx_q[1], rx_q[0]}), 32'h0143);
    serve_cmd(0, 2, 1'b0);
    check_eq("issue_latency", 32'(first_valid_cyc - last_pop_cyc), 32'd2);

    // STORE with EXT|LEN (bytes 0x19,0x00, 0x2A,0x01, 0x0F,0x00)
    push_instr(OP_STORE, 3'b011, 10'd0, 16'h012A, 16'h000F);
    serve_cmd(0, 0, 1'b0);

    // Randomised instructions with interleaved NOPs
    for (int i = 0; i < 8; i++) begin
      if (i % 3 == 0) push_word({10'($urandom_range(0, 1023)), 6'b000000});
      op  = 3'($urandom_range(1, 4));
      fl  = 3'($urandom_range(0, 7));
      inl = 10'($urandom_range(0, 1023));
      ew  = 16'($urandom_range(0, 65535));
      lw  = 16'($urandom_range(0, 65535));
      push_instr(op, fl, inl, ew, lw);
      serve_cmd($urandom_range(0, 2), $urandom_range(0, 3), 1'b0);
    end

    // Ready held low for 5 cycles, next instruction already queued
    push_instr(OP_FETCH, 3'b000, 10'd7, 16'h0, 16'h0);
    push_instr(OP_RUN, 3'b000, 10'd9, 16'h0, 16'h0);
    hs0 = hs_cnt;
    serve_cmd(5, 2, 1'b1);
    check_eq("one_handshake", 32'(hs_cnt - hs0), 32'd1);
    serve_cmd(0, 1, 1'b0);

    // Illegal opcode 6, then recovery
    push_word(16'h0006);
    push_instr(OP_RUN, 3'b000, 10'd3, 16'h0, 16'h0);
    wait_state("illegal_to_error", ST_ERROR, 20);
    check_eq("illegal_err", 32'({err, err_code}), 32'b101);
    check_eq("illegal_busy", 32'(busy), 32'd0);
    repeat (3) tick();
    check_eq("error_no_pop", 32'(rx_q.size()), 32'd2);
    pulse_start();
    check_eq("error_cleared", 32'({err, err_code}), 32'd0);
    serve_cmd(0, 1, 1'b0);

    // HALT with further bytes queued
    push_word(16'h0005);
    push_instr(OP_LOAD, 3'b000, 10'd1, 16'h0, 16'h0);
    wait_state("halt_state", ST_HALT, 20);
    check_eq("halt_flags", 32'({halted, busy, err}), 32'b100);
    repeat (3) tick();
    check_eq("halt_no_pop", 32'(rx_q.size()), 32'd2);
    check_eq("halt_rx_re", 32'(rx_re), 32'd0);
    pulse_start();
    check_eq("halt_released", 32'(halted), 32'd0);
    serve_cmd(0, 1, 1'b0);

    // Watchdog: no cmd_done
    push_instr(OP_RUN, 3'b000, 10'd2, 16'h0, 16'h0);
    serve_cmd(0, -1, 1'b0);
    wait_state("timeout_error", ST_ERROR, 40);
    tick();
    check_eq("timeout_code", 32'(err_code), 32'b10);
    check_eq("timeout_cycles", 32'(wd_last), 32'd16);
    pulse_start();
    check_eq("timeout_cleared", 32'({err, err_code}), 32'd0);

    // Reset asserted while a command is being issued
    push_instr(OP_FETCH, 3'b000, 10'h1F, 16'h0, 16'h0);
    wait_valid(20);
    #1;
    rst_n = 1'b0;
    #1;
    check_eq("arst_cmd_valid", 32'(cmd_valid), 32'd0);
    check_eq("arst_status", 32'({busy, halted, err, err_code, rx_re}), 32'd0);
    check_eq("arst_payload", 32'({cmd_op, cmd_flags, cmd_addr, cmd_len}), 32'd0);
    check_eq("arst_state", 32'(state_dbg), 32'(ST_IDLE));
    exp_q.delete();
    tick();
    rst_n = 1'b1;
    tick();

    // Partial word dropped by reset
    pulse_start();
    rx_q.push_back(8'h44);
    rx_refresh();
    repeat (3) tick();
    check_eq("partial_popped", 32'(rx_q.size()), 32'd0);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    pulse_start();
    push_instr(OP_RUN, 3'b000, 10'd5, 16'h0, 16'h0);
    serve_cmd(0, 1, 1'b0);

    repeat (3) tick();
    check_eq("sb_drained", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    n_err++;
    $display("FAIL global_timeout: simulation did not finish in time");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $fatal(1, "bench timeout");
  end

endmodule
